// File: rtl/soc_run_sequencer.sv
// Run sequencer for the MCU test harness: walks the SoC through reset, boot and run,
// and ends the run on a firmware exit write or on the watchdog.
module soc_run_sequencer #(
  parameter int unsigned RESET_WAIT_CYCLES = 4,
  parameter int unsigned BOOT_DELAY_CYCLES = 8,
  parameter int unsigned MAX_CYCLES        = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_select_i,
  output logic        soc_rst_no,
  output logic        fetch_enable_o,
  output logic        boot_select_o,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {HOLD, BOOT, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] exit_reg_q, exit_reg_d;
  logic        soc_rst_n_q, soc_rst_n_d;
  logic        fetch_en_q, fetch_en_d;
  logic        boot_sel_q, boot_sel_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        exit_valid_q, exit_valid_d;
  logic [31:0] exit_value_q, exit_value_d;
  logic        timeout_q, timeout_d;

  logic        wr_en;
  logic        wr_exit_ctrl;
  logic        wr_exit_value;
  logic        wdog_hit;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  // Byte offsets are word aligned, so the low address bits carry no information.
  assign unused_addr_bits = ^addr_i[1:0];

  assign gnt_o         = req_i;
  assign wr_en         = req_i && we_i && ((state_q == BOOT) || (state_q == RUN));
  assign wr_exit_ctrl  = wr_en && (addr_i[3:2] == 2'd0) && wdata_i[0];
  assign wr_exit_value = wr_en && (addr_i[3:2] == 2'd1);
  assign wdog_hit      = (MAX_CYCLES != 0) && (cycle_cnt_q == 32'(MAX_CYCLES - 1));

  always_comb begin
    rd_data = '0;
    case (addr_i[3:2])
      2'd0:    rd_data = {31'b0, exit_valid_q};
      2'd1:    rd_data = exit_reg_q;
      2'd2:    rd_data = {31'b0, boot_sel_q};
      2'd3:    rd_data = cycle_cnt_q;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    exit_reg_d   = exit_reg_q;
    soc_rst_n_d  = soc_rst_n_q;
    fetch_en_d   = fetch_en_q;
    boot_sel_d   = boot_sel_q;
    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;
    timeout_d    = timeout_q;
    rvalid_d     = req_i;
    rdata_d      = (req_i && !we_i) ? rd_data : '0;

    if (wr_exit_value) begin
      exit_reg_d = wdata_i;
    end

    case (state_q)
      HOLD: begin
        soc_rst_n_d = 1'b0;
        fetch_en_d  = 1'b0;
        if (cnt_q == 32'(RESET_WAIT_CYCLES - 1)) begin
          state_d     = BOOT;
          cnt_d       = '0;
          soc_rst_n_d = 1'b1;
          boot_sel_d  = boot_select_i;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      BOOT: begin
        if (cnt_q == 32'(BOOT_DELAY_CYCLES - 1)) begin
          state_d    = RUN;
          cnt_d      = '0;
          fetch_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RUN: begin
        if (cycle_cnt_q != 32'hFFFF_FFFF) begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        // A firmware exit landing on the watchdog cycle takes priority over the timeout.
        if (wr_exit_ctrl) begin
          state_d      = DONE;
          fetch_en_d   = 1'b0;
          exit_valid_d = 1'b1;
          exit_value_d = exit_reg_q;
        end else if (wdog_hit) begin
          state_d      = DONE;
          fetch_en_d   = 1'b0;
          exit_valid_d = 1'b1;
          exit_value_d = 32'hFFFF_FFFF;
          timeout_d    = 1'b1;
        end
      end
      DONE: begin
        fetch_en_d = 1'b0;
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      cycle_cnt_q  <= '0;
      exit_reg_q   <= '0;
      soc_rst_n_q  <= 1'b0;
      fetch_en_q   <= 1'b0;
      boot_sel_q   <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      exit_reg_q   <= exit_reg_d;
      soc_rst_n_q  <= soc_rst_n_d;
      fetch_en_q   <= fetch_en_d;
      boot_sel_q   <= boot_sel_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
      timeout_q    <= timeout_d;
    end
  end

  assign soc_rst_no     = soc_rst_n_q;
  assign fetch_enable_o = fetch_en_q;
  assign boot_select_o  = boot_sel_q;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;
  assign timeout_o      = timeout_q;

endmodule
